// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC mux select codes, fetch FSM states, defaults.
package cpu_pkg;

    localparam int unsigned CPU_XLEN     = 32;
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch control bundle between the pipeline and the fetch redirect controller.
interface fetch_redirect_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall;
    logic            imem_ready;
    logic            br_taken_ex;
    logic [XLEN-1:0] br_target_ex;
    logic            jalr_ex;
    logic [XLEN-1:0] jalr_target_ex;
    logic            jal_id;
    logic [XLEN-1:0] jal_target_id;
    logic [XLEN-1:0] pc;
    logic            fetch_valid;
    logic [1:0]      pc_mux_ctrl;
    logic            flush_ifid;
    logic            flush_idex;
    logic            redirect_pending;
    logic            misalign;

    modport master (
        output stall, imem_ready, br_taken_ex, br_target_ex, jalr_ex,
               jalr_target_ex, jal_id, jal_target_id,
        input  pc, fetch_valid, pc_mux_ctrl, flush_ifid, flush_idex,
               redirect_pending, misalign
    );

    modport slave (
        input  stall, imem_ready, br_taken_ex, br_target_ex, jalr_ex,
               jalr_target_ex, jal_id, jal_target_id,
        output pc, fetch_valid, pc_mux_ctrl, flush_ifid, flush_idex,
               redirect_pending, misalign
    );
endinterface

// File: rtl/fetch_redirect_ctrl_redirect_arb.sv
// Combinational redirect arbiter: source priority, target masking, PC mux
// select and flush generation. i_en gates everything off in reset/PENDING.
module redirect_arb
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = CPU_XLEN
) (
    input  logic            i_en,
    input  logic            i_stall,
    input  logic            i_br_taken,
    input  logic [XLEN-1:0] i_br_target,
    input  logic            i_jalr,
    input  logic [XLEN-1:0] i_jalr_target,
    input  logic            i_jal,
    input  logic [XLEN-1:0] i_jal_target,
    output logic            o_accept,
    output logic [XLEN-1:0] o_target,
    output logic [1:0]      o_pc_mux_ctrl,
    output logic            o_flush_ifid,
    output logic            o_flush_idex,
    output logic            o_misalign
);

    logic [XLEN-1:0] w_target_raw;

    // Priority select: EX branch, then EX JALR, then ID JAL (only when not stalled).
    always_comb begin
        o_accept      = 1'b0;
        w_target_raw  = '0;
        o_pc_mux_ctrl = PC_SEL_SEQ;
        o_flush_ifid  = 1'b0;
        o_flush_idex  = 1'b0;
        if (i_en) begin
            if (i_br_taken) begin
                o_accept      = 1'b1;
                w_target_raw  = i_br_target;
                o_pc_mux_ctrl = PC_SEL_BR;
                o_flush_ifid  = 1'b1;
                o_flush_idex  = 1'b1;
            end else if (i_jalr) begin
                o_accept      = 1'b1;
                w_target_raw  = i_jalr_target;
                o_pc_mux_ctrl = PC_SEL_JMP;
                o_flush_ifid  = 1'b1;
                o_flush_idex  = 1'b1;
            end else if (i_jal && !i_stall) begin
                o_accept      = 1'b1;
                w_target_raw  = i_jal_target;
                o_pc_mux_ctrl = PC_SEL_JMP;
                o_flush_ifid  = 1'b1;
            end
        end
    end

    // Bit 0 is always cleared; bit 1 is passed through and flagged for the trap logic.
    always_comb begin
        o_target   = {w_target_raw[XLEN-1:1], 1'b0};
        o_misalign = o_accept & w_target_raw[1];
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: sequential advance, redirect acceptance and holding a
// redirect while instruction memory is busy.
module fetch_redirect_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned     XLEN     = CPU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(CPU_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_redirect_ctrl_if.slave bus
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] r_pend_target;
    logic [XLEN-1:0] w_pend_next;

    logic            w_run;
    logic            w_accept;
    logic [XLEN-1:0] w_target;

    assign w_run = (r_state == RUN) & ~rst;

    redirect_arb #(
        .XLEN (XLEN)
    ) u_arb (
        .i_en          (w_run),
        .i_stall       (bus.stall),
        .i_br_taken    (bus.br_taken_ex),
        .i_br_target   (bus.br_target_ex),
        .i_jalr        (bus.jalr_ex),
        .i_jalr_target (bus.jalr_target_ex),
        .i_jal         (bus.jal_id),
        .i_jal_target  (bus.jal_target_id),
        .o_accept      (w_accept),
        .o_target      (w_target),
        .o_pc_mux_ctrl (bus.pc_mux_ctrl),
        .o_flush_ifid  (bus.flush_ifid),
        .o_flush_idex  (bus.flush_idex),
        .o_misalign    (bus.misalign)
    );

    // State, PC and pending-target registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_pend_target <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_pend_target <= w_pend_next;
        end
    end

    // Next-state and next-PC selection; PC only moves when imem accepts.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_pend_next  = r_pend_target;
        unique case (r_state)
            RUN: begin
                if (w_accept) begin
                    if (bus.imem_ready) begin
                        w_pc_next = w_target;
                    end else begin
                        w_pend_next  = w_target;
                        w_state_next = PENDING;
                    end
                end else if (bus.imem_ready && !bus.stall) begin
                    w_pc_next = r_pc + XLEN'(4);
                end
            end
            PENDING: begin
                if (bus.imem_ready) begin
                    w_pc_next    = r_pend_target;
                    w_state_next = RUN;
                end
            end
            default: w_state_next = RUN;
        endcase
    end

    // Registered PC and status outputs.
    always_comb begin
        bus.pc               = r_pc;
        bus.fetch_valid      = w_run & bus.imem_ready & ~bus.stall;
        bus.redirect_pending = (r_state == PENDING) & ~rst;
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: directed cases from the test plan
// followed by randomized traffic against a behavioural reference model.
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_redirect_ctrl_if #(.XLEN(32)) bus ();

    fetch_redirect_ctrl #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic [1:0]  sel;
        logic        fi;
        logic        fe;
        logic        pend;
        logic        mis;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;

    // Reference model: current PC and at most one held redirect target.
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_pend_q[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endfunction

    // Decide which redirect (if any) is taken from the current inputs.
    function automatic void arb(output logic acc, output logic ex,
                                output logic [31:0] tgt, output logic [1:0] sel);
        logic jal_ok;
        ex     = bus.br_taken_ex | bus.jalr_ex;
        jal_ok = bus.jal_id & ~bus.stall & ~ex;
        acc    = ex | jal_ok;
        tgt    = bus.br_taken_ex ? bus.br_target_ex :
                 bus.jalr_ex     ? bus.jalr_target_ex : bus.jal_target_id;
        sel    = bus.br_taken_ex ? 2'b01 : (acc ? 2'b10 : 2'b00);
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        logic acc, ex;
        logic [31:0] tgt;
        logic [1:0] sel;
        e = '{pc: m_pc, fv: 1'b0, sel: 2'b00, fi: 1'b0, fe: 1'b0, pend: 1'b0, mis: 1'b0};
        if (rst) begin
            e.pc = RST_PC;
        end else if (m_pend_q.size() != 0) begin
            e.pend = 1'b1;
        end else begin
            arb(acc, ex, tgt, sel);
            e.fv  = bus.imem_ready & ~bus.stall;
            e.sel = sel;
            e.fi  = acc;
            e.fe  = ex;
            e.mis = acc & tgt[1];
        end
        return e;
    endfunction

    function automatic void model_edge();
        logic acc, ex;
        logic [31:0] tgt;
        logic [1:0] sel;
        if (m_pend_q.size() != 0) begin
            if (bus.imem_ready) m_pc = m_pend_q.pop_front();
        end else begin
            arb(acc, ex, tgt, sel);
            if (acc) begin
                tgt[0] = 1'b0;
                if (bus.imem_ready) m_pc = tgt;
                else m_pend_q.push_back(tgt);
            end else if (bus.imem_ready && !bus.stall) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endfunction

    // One cycle of stimulus: apply inputs, queue the expectation, advance the model.
    task automatic drive(input logic r, input logic stl, input logic rdy,
                         input logic br, input logic [31:0] brt,
                         input logic jr, input logic [31:0] jrt,
                         input logic jl, input logic [31:0] jlt);
        rst                = r;
        bus.stall          = stl;
        bus.imem_ready     = rdy;
        bus.br_taken_ex    = br;
        bus.br_target_ex   = brt;
        bus.jalr_ex        = jr;
        bus.jalr_target_ex = jrt;
        bus.jal_id         = jl;
        bus.jal_target_id  = jlt;
        if (r) begin
            m_pc = RST_PC;
            m_pend_q.delete();
        end
        sb_q.push_back(expect_now());
        @(posedge clk);
        if (!r) model_edge();
        #1;
    endtask

    task automatic idle(input logic rdy, input logic stl);
        drive(1'b0, stl, rdy, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        logic viol;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("pc",               bus.pc,                        e.pc);
                chk("fetch_valid",      {31'b0, bus.fetch_valid},      {31'b0, e.fv});
                chk("pc_mux_ctrl",      {30'b0, bus.pc_mux_ctrl},      {30'b0, e.sel});
                chk("flush_ifid",       {31'b0, bus.flush_ifid},       {31'b0, e.fi});
                chk("flush_idex",       {31'b0, bus.flush_idex},       {31'b0, e.fe});
                chk("redirect_pending", {31'b0, bus.redirect_pending}, {31'b0, e.pend});
                chk("misalign",         {31'b0, bus.misalign},         {31'b0, e.mis});
                if (bus.redirect_pending) begin
                    viol = bus.br_taken_ex | bus.jalr_ex | bus.jal_id;
                    chk("no_redirect_in_pending", {31'b0, viol}, 32'h0);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic r, stl, rdy, br, jr, jl;
        bus.stall = 1'b0; bus.imem_ready = 1'b0;
        bus.br_taken_ex = 1'b0; bus.br_target_ex = '0;
        bus.jalr_ex = 1'b0; bus.jalr_target_ex = '0;
        bus.jal_id = 1'b0; bus.jal_target_id = '0;
        @(posedge clk);
        #1;
        // Reset held
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        // Sequential fetch 0,4,8,C
        repeat (4) idle(1'b1, 1'b0);
        // Branch beats same-cycle JAL
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        idle(1'b1, 1'b0);
        // JAL under stall ignored, then accepted
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h40);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h40);
        idle(1'b1, 1'b0);
        // Misaligned JALR held while imem busy
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h203, 1'b0, 32'h0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        // PC wrap
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        // Reset in the middle of PENDING
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            stl = ($urandom_range(0, 4) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            br  = 1'b0; jr = 1'b0; jl = 1'b0;
            if (m_pend_q.size() == 0) begin
                br = ($urandom_range(0, 7) == 0);
                jr = ($urandom_range(0, 7) == 0);
                jl = ($urandom_range(0, 5) == 0);
            end
            drive(r, stl, rdy, br, $urandom(), jr, $urandom(), jl, $urandom());
        end
        idle(1'b1, 1'b0);
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
